reg_dump: RTL and testbench
===========================

// Module: reg_dump
// PURPOSE
//   Debug read-out engine for the 8-entry, 16-bit register file. On a start pulse it takes
//   over one asynchronous read port, walks the register addresses in order, and streams each
//   word out on a valid/ready interface tagged with its address.
//   Sits between the register file and the debug/trace channel; the core is stalled while it runs.
// PARAMETERS
//   p_WORD_LEN      16  register word width
//   p_REG_ADDR_LEN  3   register address width
//   p_REG_FILE_SIZE 8   number of registers (addresses 0..p_REG_FILE_SIZE-1)
//   p_SKIP_ZERO     1   1: start walk at r1 (r0 is hardwired 0); 0: start at r0
// PORTS
//   i_clk      in   1               clock, all state updates on posedge
//   i_rst_n    in   1               asynchronous active-low reset
//   i_start    in   1               request a dump; sampled only in IDLE
//   i_abort    in   1               abandon dump in progress, synchronous
//   o_src      out  p_REG_ADDR_LEN  read address driven to register file read port
//   i_src_data in   p_WORD_LEN      asynchronous read data for o_src
//   o_stall    out  1               high while the read port is owned (core must hold)
//   o_valid    out  1               o_data/o_addr hold a word for the consumer
//   i_ready    in   1               consumer accepts word when o_valid && i_ready at posedge
//   o_data     out  p_WORD_LEN      captured register value
//   o_addr     out  p_REG_ADDR_LEN  register address of o_data
//   o_done     out  1               one-cycle pulse after the last word is accepted
// BEHAVIOUR
//   Reset (i_rst_n=0, async): state=IDLE, o_src=0, o_stall=0, o_valid=0, o_data=0, o_addr=0,
//     o_done=0, internal addr counter=first address. Reset mid-dump discards everything.
//   first = p_SKIP_ZERO ? 1 : 0; last = p_REG_FILE_SIZE-1.
//   States: IDLE, READ, SEND, DONE. o_stall = (state != IDLE).
//   IDLE: counter=first. i_start && !i_abort -> READ. Otherwise stay in IDLE.
//   READ (1 cycle): o_src=counter. At the posedge, o_data<=i_src_data, o_addr<=counter,
//     o_valid<=1, -> SEND.
//   SEND: o_valid=1; o_data/o_addr stable until accepted. o_src keeps the counter value.
//     On i_ready: o_valid<=0.
//       If counter==last -> DONE.
//       Else counter<=counter+1 -> READ.
//     Without i_ready, stay in SEND indefinitely.
//   DONE (1 cycle): o_done=1, counter<=first -> IDLE.
//   Throughput: 2 cycles per word minimum.
//     Dump of r1..r7 with i_ready tied high: start edge + 14 cycles + 1 DONE cycle.
//   Counter arithmetic is modulo 2^p_REG_ADDR_LEN; it never passes last, so no wrap occurs.
//   i_start outside IDLE: ignored (no queueing, no restart).
//   i_abort in READ/SEND/DONE: next state IDLE; o_valid<=0, o_done<=0, counter<=first.
//     A word pending in SEND is dropped even if i_ready is high in the same cycle.
//   i_start and i_abort together in IDLE: abort wins, stay IDLE.
//   o_src is 0 in IDLE.
//   The block never writes the register file; it is a pure reader.
//   Register contents changing during a dump: each word reflects its value at that word's READ cycle.
// TESTING
//   1 Preload r1..r7=0x1111*i, p_SKIP_ZERO=1, i_ready=1, pulse i_start
//       -> 7 words (addr 1..7, data 0x1111..0x7777), o_done pulses 1 cycle after addr 7 is accepted,
//          o_stall high for exactly 15 cycles.
//   2 p_SKIP_ZERO=0, same preload
//       -> first word addr 0 data 0x0000, 8 words total, last word addr 7 data 0x7777.
//   3 Backpressure: i_ready=0 for 5 cycles at addr 3
//       -> o_valid held, o_data=0x3333 and o_addr=3 stable, no skipped or duplicated address.
//   4 i_abort asserted while in SEND at addr 4 with i_ready=1
//       -> next cycle IDLE, o_valid=0, o_stall=0, no o_done; a new i_start restarts at addr 1.
//   5 i_start pulsed again at addr 2 mid-dump
//       -> ignored, dump completes normally with 7 words.
//     i_start and i_abort together in IDLE -> stays IDLE.
//   6 i_rst_n low for 1 cycle while in READ at addr 5
//       -> all outputs 0 immediately (async), IDLE after release, no further words.

Source files
------------

// File: rtl/reg_dump.sv
// reg_dump: debug read-out engine for the register file.
// On a start request it owns one asynchronous read port. It walks the register
// addresses in order and streams each word out on a valid/ready channel, tagged
// with its address.
module reg_dump #(
    parameter int p_WORD_LEN      = 16,
    parameter int p_REG_ADDR_LEN  = 3,
    parameter int p_REG_FILE_SIZE = 8,
    parameter int p_SKIP_ZERO     = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic                      i_abort,
    output logic [p_REG_ADDR_LEN-1:0] o_src,
    input  logic [p_WORD_LEN-1:0]     i_src_data,
    output logic                      o_stall,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [p_WORD_LEN-1:0]     o_data,
    output logic [p_REG_ADDR_LEN-1:0] o_addr,
    output logic                      o_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // r0 is hardwired to zero, so the walk can optionally start at r1
    localparam logic [p_REG_ADDR_LEN-1:0] FIRST = p_REG_ADDR_LEN'((p_SKIP_ZERO != 0) ? 1 : 0);
    localparam logic [p_REG_ADDR_LEN-1:0] LAST  = p_REG_ADDR_LEN'(p_REG_FILE_SIZE - 1);

    logic [1:0]                state;
    logic [p_REG_ADDR_LEN-1:0] counter;

    // The read port is released to the core only while idle
    assign o_stall = (state != S_IDLE);
    assign o_src   = (state == S_IDLE) ? '0 : counter;

    // Walk sequencer: capture in READ, hold in SEND until accepted, pulse done at the end.
    // An abort outside IDLE wins over everything and drops any pending word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            counter <= FIRST;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_addr  <= '0;
            o_done  <= 1'b0;
        end else if (i_abort && (state != S_IDLE)) begin
            state   <= S_IDLE;
            counter <= FIRST;
            o_valid <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    counter <= FIRST;
                    o_valid <= 1'b0;
                    o_done  <= 1'b0;
                    if (i_start && !i_abort) begin
                        state <= S_READ;
                    end
                end
                S_READ: begin
                    o_data  <= i_src_data;
                    o_addr  <= counter;
                    o_valid <= 1'b1;
                    state   <= S_SEND;
                end
                S_SEND: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (counter == LAST) begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            counter <= counter + 1'b1;
                            state   <= S_READ;
                        end
                    end
                end
                default: begin
                    o_done  <= 1'b0;
                    counter <= FIRST;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: self-checking bench for reg_dump.
// Two instances run side by side, one starting the walk at r1 and one at r0.
// The expected word stream is built from the register array and the address range.
// The expected stall length comes from the count of words and the consumer wait cycles.
module tb_reg_dump;

    typedef struct {
        int hold_addr;
        int hold_cycles;
        int restart_addr;
        bit random_ready;
        bit random_regs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready1 = 1'b1;
    logic        ready0 = 1'b1;
    logic [15:0] regs [8];

    logic [2:0]  src1, src0, addr1, addr0;
    logic [15:0] rdata1, rdata0, word1, word0;
    logic        stall1, stall0, valid1, valid0, done1, done0;

    int checks = 0;
    int fails  = 0;

    assign rdata1 = regs[src1];
    assign rdata0 = regs[src0];

    reg_dump #(.p_SKIP_ZERO(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_src(src1), .i_src_data(rdata1), .o_stall(stall1), .o_valid(valid1),
        .i_ready(ready1), .o_data(word1), .o_addr(addr1), .o_done(done1)
    );

    reg_dump #(.p_SKIP_ZERO(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .o_src(src0), .i_src_data(rdata0), .o_stall(stall0), .o_valid(valid0),
        .i_ready(ready0), .o_data(word0), .o_addr(addr0), .o_done(done0)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 8; i++) regs[i] = 16'(16'h1111 * i);
    endtask

    // Run one full dump on both instances and score the word streams
    task automatic applyStimulus(input vec_t v);
        int  exp1 = 1, exp0 = 0;
        int  n1 = 0, n0 = 0, wait1 = 0, wait0 = 0, held = 0;
        int  stallCnt1 = 0, stallCnt0 = 0, doneCnt1 = 0, doneCnt0 = 0;
        int  lastAcc1 = -10, lastAcc0 = -10;
        bit  fin1 = 0, fin0 = 0;
        ready1 = 1'b1;
        ready0 = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400 && !(fin1 && fin0); cyc++) begin
            if (stall1) stallCnt1++;
            if (stall0) stallCnt0++;
            if (done1) begin
                doneCnt1++;
                fin1 = 1;
                checkOutput("done1_after_last_word", cyc, lastAcc1 + 1);
            end
            if (done0) begin
                doneCnt0++;
                fin0 = 1;
                checkOutput("done0_after_last_word", cyc, lastAcc0 + 1);
            end
            ready1 = v.random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            ready0 = v.random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (valid1 && int'(addr1) == v.hold_addr && held < v.hold_cycles) begin
                ready1 = 1'b0;
                held++;
                checkOutput("hold_addr", addr1, v.hold_addr);
                checkOutput("hold_data", word1, regs[v.hold_addr]);
            end
            start = (v.restart_addr >= 0 && valid1 && int'(addr1) == v.restart_addr);
            if (valid1 && !ready1) wait1++;
            if (valid0 && !ready0) wait0++;
            if (valid1 && ready1) begin
                checkOutput("word1_addr", addr1, exp1);
                checkOutput("word1_data", word1, regs[exp1]);
                exp1++;
                n1++;
                lastAcc1 = cyc;
            end
            if (valid0 && ready0) begin
                checkOutput("word0_addr", addr0, exp0);
                checkOutput("word0_data", word0, regs[exp0]);
                exp0++;
                n0++;
                lastAcc0 = cyc;
            end
            @(negedge clk);
        end
        start  = 1'b0;
        ready1 = 1'b1;
        ready0 = 1'b1;
        checkOutput("dump_finished", {30'd0, fin1, fin0}, 32'd3);
        checkOutput("word1_count", n1, 7);
        checkOutput("word0_count", n0, 8);
        checkOutput("done1_pulses", doneCnt1, 1);
        checkOutput("done0_pulses", doneCnt0, 1);
        checkOutput("stall1_cycles", stallCnt1, 2 * 7 + 1 + wait1);
        checkOutput("stall0_cycles", stallCnt0, 2 * 8 + 1 + wait0);
        checkOutput("idle_after_dump", {28'd0, stall1, stall0, done1, done0}, 32'd0);
    endtask

    initial begin
        vec_t vecs [5];
        bit   sawActivity;
        vecs[0] = '{hold_addr: -1, hold_cycles: 0, restart_addr: -1, random_ready: 0, random_regs: 0};
        vecs[1] = '{hold_addr:  3, hold_cycles: 5, restart_addr: -1, random_ready: 0, random_regs: 0};
        vecs[2] = '{hold_addr: -1, hold_cycles: 0, restart_addr:  2, random_ready: 0, random_regs: 0};
        vecs[3] = '{hold_addr:  5, hold_cycles: 3, restart_addr: -1, random_ready: 1, random_regs: 1};
        vecs[4] = '{hold_addr: -1, hold_cycles: 0, restart_addr: -1, random_ready: 1, random_regs: 1};

        preload();
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs1", {src1, stall1, valid1, word1, addr1, done1}, 32'd0);
        checkOutput("reset_outputs0", {src0, stall0, valid0, word0, addr0, done0}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].random_regs) begin
                for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
            end else begin
                preload();
            end
            applyStimulus(vecs[v]);
        end

        // Start and abort together while idle: abort wins
        preload();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_idle", {stall1, stall0}, 32'd0);

        // Abort while r4 is pending and the consumer is ready: word dropped, no done
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !(valid1 && addr1 == 3'd4); i++) @(negedge clk);
        checkOutput("abort_reached_addr4", {31'd0, valid1 && addr1 == 3'd4}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_outputs", {stall1, valid1, done1, stall0, valid0, done0}, 32'd0);
        sawActivity = 0;
        repeat (4) begin
            if (done1 || valid1 || stall1) sawActivity = 1;
            @(negedge clk);
        end
        checkOutput("abort_quiet", {31'd0, sawActivity}, 32'd0);
        applyStimulus(vecs[0]);

        // Asynchronous reset while reading r5
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && !(stall1 && !valid1 && src1 == 3'd5); i++) @(negedge clk);
        checkOutput("reset_reached_read5", {31'd0, stall1 && !valid1 && src1 == 3'd5}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset1", {src1, stall1, valid1, word1, addr1, done1}, 32'd0);
        checkOutput("async_reset0", {src0, stall0, valid0, word0, addr0, done0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawActivity = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid1 || stall1 || done1 || valid0 || stall0) sawActivity = 1;
        end
        checkOutput("quiet_after_reset", {31'd0, sawActivity}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
